mvm_host_driver: RTL and testbench
==================================

# mvm_host_driver

Host-side initiator for the team's `loadMatrix`/`loadVector`/`start`/`done` matrix-vector multiplier interface. It accepts operand words from an upstream valid/ready stream at any pace and buffers one full job. It then drives the gap-free load bursts and the start pulse into the multiplier. After `done`, it captures the K result words and releases them on a downstream valid/ready stream with a last-word marker.

## Interface
- K, 8, matrix dimension; a job is K*K matrix words (row-major) then K vector words
- B, 8, operand width; result width is 2*B
- TIMEOUT, 256, maximum cycles from the start pulse to `done` before the job is abandoned
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  reset, synchronous, active-high
- in_valid / in_ready  in / out  1 / 1  upstream operand handshake
- in_data  in  B  signed operand word
- reuse_matrix  in  1  sampled with the first accepted word of a job; 1 means the job carries only K vector words
- mvm_load_matrix / mvm_load_vector / mvm_start  out  1  one-cycle pulses to the multiplier
- mvm_data  out  B  operand word to the multiplier; 0 when not bursting
- mvm_done  in  1  multiplier completion pulse
- mvm_result  in  2B  result word; valid on the K cycles following `mvm_done`
- out_valid / out_ready  out / in  1 / 1  downstream result handshake
- out_data  out  2B  result word; out_last  out  1  marks the K-th word of a job
- busy  out  1  FSM not in IDLE; timeout  out  1  one-cycle pulse on abandoned job

## Operation
- States: IDLE, FILL, LOAD_M, LOAD_V, START, WAIT, COLLECT.
- Operand buffer: K*K+K entries.
- Result buffer: K-entry FIFO.
- matrix_valid flag: set when a LOAD_M burst completes; cleared by reset and by timeout.
- IDLE/FILL: in_ready = 1.
  - The first accepted word latches `job_vec_only = reuse_matrix & matrix_valid`. If `reuse_matrix` = 1 but matrix_valid = 0, the job is treated as a full job.
  - Job length L is K when job_vec_only, else K*K+K.
  - Vector-only words are stored at operand buffer offset K*K; the stored matrix is preserved.
  - Gaps in in_valid are allowed. in_ready drops on the edge that accepts word L.
- Leaving FILL: go to LOAD_M, or directly to LOAD_V when job_vec_only.
- LOAD_M:
  - `mvm_load_matrix` is high for the first cycle.
  - `mvm_data` carries matrix words 0..K*K-1 on the next K*K consecutive cycles.
- LOAD_V: same pattern, with `mvm_load_vector` and K vector words.
- START:
  - Pulse `mvm_start` in the first cycle in which the result FIFO is empty.
  - Until then, hold in START with `mvm_start` = 0.
- WAIT:
  - A counter is cleared at the start pulse.
  - `mvm_done` moves the FSM to COLLECT.
  - If the counter reaches TIMEOUT first: pulse `timeout`, clear matrix_valid, go to IDLE, discard the job.
- COLLECT:
  - Write `mvm_result` into the FIFO on each of the K cycles after `mvm_done`.
  - Tag the K-th entry as last.
  - Go to IDLE after the K-th write.
- Output side runs independently of the FSM:
  - out_valid = FIFO not empty; out_data / out_last come from the FIFO head.
  - The FIFO pops on out_valid & out_ready.
  - FIFO overflow cannot occur because START waits for an empty FIFO.
  - The next job's FILL overlaps draining of the previous results.
- `mvm_done` outside WAIT is ignored.
- `mvm_result` is treated as opaque 2B bits; no arithmetic is done on it.

## Timing
- Reset (synchronous):
  - State returns to IDLE; both buffers are emptied; matrix_valid = 0.
  - All outputs are 0, except in_ready = 1, in the cycle after reset is sampled.
  - Reset mid-burst aborts the burst with no further pulses.
- Let A be the cycle of the last accepted word.
- Full job:
  - load_matrix at A+1; matrix words at A+2..A+K*K+1.
  - load_vector at A+K*K+2; vector words at A+K*K+3..A+K*K+K+2.
  - start at A+K*K+K+3 if the FIFO is empty.
- Vector-only job: load_vector at A+1; start at A+K+2.
- Let D be the cycle `mvm_done` is high. Captures happen at D+1..D+K; the first out_valid is at D+2.
- Simultaneous FIFO write and pop in the same cycle are both honored.

## Test plan
- Full job, K=8, B=8:
  - Stimulus: identity matrix, vector 1..8; model asserts done 70 cycles after start.
  - Check: load_matrix exactly at A+1, load_vector at A+66, start at A+75.
  - Check: outputs 16'd1..16'd8, out_last only on 16'd8.
- Vector-only job after the first: reuse_matrix = 1, vector -1..-8.
  - Check: no load_matrix pulse; load_vector at A+1.
  - Check: results 16'hFFFF..16'hFFF8.
- Backpressure: hold out_ready = 0 after job 1 and load job 2.
  - Check: job 2 sits in START with mvm_start = 0.
  - Check: mvm_start fires one cycle after the 8th result is popped.
- Upstream gaps: in_valid toggling 1/0 during FILL.
  - Check: mvm_data burst is still 64 + 8 consecutive cycles.
- Timeout: model never asserts done.
  - Check: timeout pulse at start+256; busy falls.
  - Check: a following reuse_matrix = 1 job expects 72 words and issues load_matrix.
- Reset asserted during LOAD_M word 20.
  - Check: all mvm_* outputs 0 the next cycle; in_ready = 1; out_valid = 0.

Source files
------------

// File: rtl/mvm_host_driver.sv
// mvm_host_driver: buffers one operand job from a valid/ready stream, replays it into the
// multiplier as gap-free load bursts plus a start pulse, then streams the K results back out.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_data/reuse_matrix upstream operands;
// mvm_load_matrix/mvm_load_vector/mvm_start/mvm_data/mvm_done/mvm_result multiplier side;
// out_valid/out_ready/out_data/out_last downstream results; busy (FSM not idle); timeout pulse.
module mvm_host_driver #(
    parameter int K       = 8,
    parameter int B       = 8,
    parameter int TIMEOUT = 256
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [B-1:0]   in_data,
    input  logic           reuse_matrix,
    output logic           mvm_load_matrix,
    output logic           mvm_load_vector,
    output logic           mvm_start,
    output logic [B-1:0]   mvm_data,
    input  logic           mvm_done,
    input  logic [2*B-1:0] mvm_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*B-1:0] out_data,
    output logic           out_last,
    output logic           busy,
    output logic           timeout
);
    localparam int MM = K * K;
    localparam int N  = MM + K;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(N + TIMEOUT + 1);
    localparam int FW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {IDLE, FILL, LOAD_M, LOAD_V, START, WAIT, COLLECT} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, fill_idx, job_len;
    logic [B-1:0] op_buf [N];
    logic [2*B:0] res_fifo [K];
    logic [FW-1:0] rd_ptr, wr_ptr;
    logic [FW:0] fifo_cnt;
    logic [AW-1:0] wr_addr, rd_addr;
    logic matrix_valid, vec_only, vec_now, accept, pop, fifo_wr, set_mv, clr_mv;

    function automatic logic [FW-1:0] nxt(input logic [FW-1:0] p);
        return (p == FW'(K - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready = (state == IDLE) || (state == FILL);
    assign busy     = state != IDLE;
    assign accept   = in_valid & in_ready;
    assign out_valid = fifo_cnt != '0;
    assign pop       = out_valid & out_ready;
    assign {out_last, out_data} = out_valid ? res_fifo[rd_ptr] : '0;

    // In IDLE the counter may hold a stale value; the first word always lands at offset 0 of its job.
    assign fill_idx = (state == IDLE) ? '0 : cnt;
    assign vec_now  = (state == IDLE) ? (reuse_matrix & matrix_valid) : vec_only;
    assign job_len  = vec_now ? CW'(K) : CW'(N);
    // Vector-only jobs write behind the stored matrix so it survives for reuse.
    assign wr_addr  = (vec_now ? AW'(MM) : '0) + AW'(fill_idx);
    // Burst cycle 0 is the load pulse, so word i appears when cnt = i+1.
    assign rd_addr  = ((state == LOAD_V) ? AW'(MM) : '0) + AW'(cnt) - AW'(1);

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        mvm_load_matrix = 1'b0;
        mvm_load_vector = 1'b0;
        mvm_start       = 1'b0;
        mvm_data        = '0;
        timeout         = 1'b0;
        fifo_wr         = 1'b0;
        set_mv          = 1'b0;
        clr_mv          = 1'b0;
        case (state)
            IDLE, FILL: begin
                if (accept) begin
                    state_nx = FILL;
                    cnt_nx   = fill_idx + 1'b1;
                    if (fill_idx + 1'b1 == job_len) begin
                        state_nx = vec_now ? LOAD_V : LOAD_M;
                        cnt_nx   = '0;
                    end
                end
            end
            LOAD_M: begin
                mvm_load_matrix = cnt == '0;
                mvm_data        = (cnt == '0) ? '0 : op_buf[rd_addr];
                cnt_nx          = cnt + 1'b1;
                if (cnt == CW'(MM)) begin
                    state_nx = LOAD_V;
                    cnt_nx   = '0;
                    set_mv   = 1'b1;
                end
            end
            LOAD_V: begin
                mvm_load_vector = cnt == '0;
                mvm_data        = (cnt == '0) ? '0 : op_buf[rd_addr];
                cnt_nx          = cnt + 1'b1;
                if (cnt == CW'(K)) begin
                    state_nx = START;
                    cnt_nx   = '0;
                end
            end
            START: begin
                // An empty FIFO guarantees room for all K results of this job.
                if (fifo_cnt == '0) begin
                    mvm_start = 1'b1;
                    state_nx  = WAIT;
                    cnt_nx    = '0;
                end
            end
            WAIT: begin
                cnt_nx = cnt + 1'b1;
                if (mvm_done) begin
                    state_nx = COLLECT;
                    cnt_nx   = '0;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timeout  = 1'b1;
                    clr_mv   = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            COLLECT: begin
                fifo_wr = 1'b1;
                cnt_nx  = cnt + 1'b1;
                if (cnt == CW'(K - 1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            matrix_valid <= 1'b0;
            vec_only     <= 1'b0;
        end else begin
            if (clr_mv)
                matrix_valid <= 1'b0;
            else if (set_mv)
                matrix_valid <= 1'b1;
            if (accept && state == IDLE)
                vec_only <= vec_now;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            op_buf[wr_addr] <= in_data;
        if (fifo_wr)
            res_fifo[wr_ptr] <= {cnt == CW'(K - 1), mvm_result};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            fifo_cnt <= fifo_cnt + (FW + 1)'(fifo_wr) - (FW + 1)'(pop);
        end
    end
endmodule

// File: tb/tb_mvm_host_driver.sv
// tb_mvm_host_driver: drives random and directed jobs into mvm_host_driver with a behavioural
// multiplier model, and checks pulse timing plus a result scoreboard fed from the stimulus.
module tb_mvm_host_driver;
    localparam int K = 8, B = 8, T = 256, LAT = 70;

    logic clk = 1'b0, reset = 1'b1;
    logic in_valid = 1'b0, in_ready, reuse_matrix = 1'b0;
    logic [B-1:0] in_data = '0, mvm_data;
    logic mvm_load_matrix, mvm_load_vector, mvm_start, mvm_done = 1'b0;
    logic [2*B-1:0] mvm_result = '0, out_data;
    logic out_valid, out_ready = 1'b0, out_last, busy, timeout;

    mvm_host_driver #(.K(K), .B(B), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .reuse_matrix(reuse_matrix), .mvm_load_matrix(mvm_load_matrix),
        .mvm_load_vector(mvm_load_vector), .mvm_start(mvm_start), .mvm_data(mvm_data),
        .mvm_done(mvm_done), .mvm_result(mvm_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    logic [2*B:0] exp_q[$];
    logic [2*B:0] sb_e;
    int mat[K*K], vec[K], ref_m[K*K];
    bit mv_ref = 0, done_en = 1, rand_ready = 0, ready_force = 1;
    int lm_cyc, lv_cyc, st_cyc, to_cyc, pop_cyc;
    int lm_cnt = 0, lv_cnt = 0, st_cnt = 0, to_cnt = 0, pop_cnt = 0;

    int mmode = 0, midx = 0, cd = 0, eidx = 0, acc_m;
    bit emit = 0;
    int mm_cap[K*K], vv_cap[K];
    logic [2*B-1:0] mres[K];

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int sel(input int w);
        return w == 0 ? lm_cnt : w == 1 ? lv_cnt : w == 2 ? st_cnt : w == 3 ? to_cnt : pop_cnt;
    endfunction

    // Monitor, scoreboard and multiplier model share one process so their order per cycle is fixed.
    always @(negedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(1) != 0) : ready_force;
        if (!reset) begin
            if (mvm_load_matrix) begin lm_cyc = cyc; lm_cnt++; end
            if (mvm_load_vector) begin lv_cyc = cyc; lv_cnt++; end
            if (mvm_start) begin st_cyc = cyc; st_cnt++; end
            if (timeout) begin to_cyc = cyc; to_cnt++; end
            if (out_valid && out_ready) begin
                pop_cnt++;
                pop_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got %h expected no result", {out_last, out_data});
                end else begin
                    sb_e = exp_q.pop_front();
                    if ({out_last, out_data} !== sb_e) begin
                        errors++;
                        $display("FAIL sb_result: got last=%0b data=%h expected last=%0b data=%h",
                                 out_last, out_data, sb_e[2*B], sb_e[2*B-1:0]);
                    end
                end
            end
        end
        if (reset) begin
            mmode = 0; cd = 0; emit = 0;
            mvm_done = 1'b0; mvm_result = '0;
        end else begin
            if (mmode == 1) begin
                mm_cap[midx] = int'($signed(mvm_data));
                midx++;
                if (midx == K*K) mmode = 0;
            end else if (mmode == 2) begin
                vv_cap[midx] = int'($signed(mvm_data));
                midx++;
                if (midx == K) mmode = 0;
            end
            if (mvm_load_matrix) begin mmode = 1; midx = 0; end
            if (mvm_load_vector) begin mmode = 2; midx = 0; end
            mvm_done = 1'b0;
            mvm_result = '0;
            if (emit) begin
                mvm_result = mres[eidx];
                eidx++;
                emit = eidx < K;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mvm_done = 1'b1;
                    for (int i = 0; i < K; i++) begin
                        acc_m = 0;
                        for (int j = 0; j < K; j++) acc_m += mm_cap[i*K+j] * vv_cap[j];
                        mres[i] = acc_m[2*B-1:0];
                    end
                    emit = 1;
                    eidx = 0;
                end
            end
            if (mvm_start && done_en) cd = LAT;
        end
    end

    task automatic push_exp();
        int acc;
        for (int i = 0; i < K; i++) begin
            acc = 0;
            for (int j = 0; j < K; j++) acc += ref_m[i*K+j] * vec[j];
            exp_q.push_back({(i == K - 1), acc[2*B-1:0]});
        end
    endtask

    task automatic randomize_job();
        for (int i = 0; i < K*K; i++) mat[i] = int'($urandom_range(255)) - 128;
        for (int i = 0; i < K; i++) vec[i] = int'($urandom_range(255)) - 128;
    endtask

    // Called at a negedge; returns at the negedge after the last accepted word, a = its cycle.
    task automatic feed(input bit reuse, input bit gaps, input bit expect_res, output int a);
        bit vo;
        int n, w, tmo;
        vo = reuse && mv_ref;
        n = vo ? K : K*K + K;
        a = 0;
        if (!vo) begin ref_m = mat; mv_ref = 1; end
        if (expect_res) push_exp();
        reuse_matrix = reuse;
        for (int i = 0; i < n; i++) begin
            w = vo ? vec[i] : (i < K*K ? mat[i] : vec[i-K*K]);
            if (gaps && i % 2 == 1) begin in_valid = 1'b0; @(negedge clk); end
            in_valid = 1'b1;
            in_data = w[B-1:0];
            tmo = 0;
            while (!in_ready && tmo < 600) begin @(negedge clk); tmo++; end
            if (!in_ready) begin
                checks++; errors++;
                $display("FAIL fill_stall: word %0d of %0d not accepted within 600 cycles", i, n);
                in_valid = 1'b0;
                return;
            end
            a = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        reuse_matrix = 1'b0;
    endtask

    task automatic wait_for(input string name, input int w, input int base, input int lim);
        int t = 0;
        while (sel(w) <= base && t < lim) begin @(negedge clk); t++; end
        if (sel(w) <= base) begin
            checks++; errors++;
            $display("FAIL %s: event not seen within %0d cycles", name, lim);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin @(negedge clk); t++; end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy && t < 500) begin @(negedge clk); t++; end
        chk(name, int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, base, base2, p;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_outputs", int'({mvm_load_matrix, mvm_load_vector, mvm_start, mvm_data, busy,
                                 timeout, out_valid, out_last, out_data}), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < K*K; i++) mat[i] = (i / K == i % K) ? 1 : 0;
        for (int i = 0; i < K; i++) vec[i] = i + 1;
        base = st_cnt;
        feed(0, 0, 1, a);
        wait_for("j1_start", 2, base, 200);
        chk("j1_load_matrix_cyc", lm_cyc, a + 1);
        chk("j1_load_vector_cyc", lv_cyc, a + K*K + 2);
        chk("j1_start_cyc", st_cyc, a + K*K + K + 3);
        drain("j1_drain");

        for (int i = 0; i < K; i++) vec[i] = -(i + 1);
        base = st_cnt;
        base2 = lm_cnt;
        feed(1, 0, 1, a);
        wait_for("j2_start", 2, base, 100);
        chk("j2_no_load_matrix", lm_cnt, base2);
        chk("j2_load_vector_cyc", lv_cyc, a + 1);
        chk("j2_start_cyc", st_cyc, a + K + 2);
        drain("j2_drain");

        ready_force = 0;
        randomize_job();
        base = st_cnt;
        feed(0, 0, 1, a);
        wait_for("j3_start", 2, base, 200);
        wait_idle("j3_collected");
        for (int i = 0; i < K; i++) vec[i] = int'($urandom_range(255)) - 128;
        base = st_cnt;
        feed(1, 0, 1, a);
        repeat (30) @(negedge clk);
        chk("bp_busy", int'(busy), 1);
        chk("bp_no_start", st_cnt, base);
        base2 = pop_cnt;
        ready_force = 1;
        wait_for("bp_pops", 4, base2 + K - 1, 100);
        p = pop_cyc;
        wait_for("bp_start", 2, base, 50);
        chk("bp_start_cyc", st_cyc, p + 1);
        drain("bp_drain");

        rand_ready = 1;
        randomize_job();
        base = st_cnt;
        feed(0, 1, 1, a);
        wait_for("gap_start", 2, base, 200);
        chk("gap_load_matrix_cyc", lm_cyc, a + 1);
        chk("gap_matrix_burst", lv_cyc - lm_cyc, K*K + 1);
        chk("gap_vector_burst", st_cyc - lv_cyc, K + 1);
        drain("gap_drain");

        done_en = 0;
        randomize_job();
        base = st_cnt;
        base2 = to_cnt;
        feed(0, 0, 0, a);
        wait_for("to_start", 2, base, 200);
        wait_for("to_pulse", 3, base2, 400);
        chk("to_pulse_cyc", to_cyc, st_cyc + T);
        chk("to_busy_fall", int'(busy), 0);
        mv_ref = 0;
        done_en = 1;

        randomize_job();
        base = st_cnt;
        feed(1, 0, 1, a);
        chk("j7_in_ready_drop", int'(in_ready), 0);
        wait_for("j7_start", 2, base, 200);
        chk("j7_load_matrix_cyc", lm_cyc, a + 1);
        drain("j7_drain");

        rand_ready = 0;
        ready_force = 1;
        randomize_job();
        base = lm_cnt;
        feed(0, 0, 0, a);
        wait_for("rst_load_matrix", 0, base, 20);
        while (cyc < lm_cyc + 21) @(negedge clk);
        chk("rst_burst_word20", int'(mvm_data), mat[20] & 8'hFF);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mvm_outputs", int'({mvm_load_matrix, mvm_load_vector, mvm_start, mvm_data}), 0);
        chk("rst_in_ready_mid", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        reset = 1'b0;
        mv_ref = 0;
        @(negedge clk);

        rand_ready = 1;
        randomize_job();
        base = st_cnt;
        feed(1, 0, 1, a);
        wait_for("j9_start", 2, base, 200);
        chk("j9_load_matrix_cyc", lm_cyc, a + 1);
        for (int i = 0; i < K; i++) vec[i] = int'($urandom_range(255)) - 128;
        base = st_cnt;
        feed(1, 1, 1, a);
        wait_for("j10_start", 2, base, 300);
        chk("j10_load_vector_cyc", lv_cyc, a + 1);
        drain("j10_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
